// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the multicycle MIPS control path:
//   - state_t      : control FSM states
//   - OP_* / FUNCT_*: opcodes and R-type function codes this core executes
//   - ula_ctrl_t   : 4-bit operation code consumed by the 32-bit ULA
//   - SRCA_* / SRCB_* / PCSRC_* : datapath multiplexer select encodings
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_ALUWB,
        S_BRANCH,
        S_ADDI_EX,
        S_ADDI_WB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_SLL = 6'b000000;
    localparam logic [5:0] FUNCT_SRL = 6'b000010;
    localparam logic [5:0] FUNCT_SRA = 6'b000011;

    typedef enum logic [3:0] {
        ULA_ADD = 4'b0000,
        ULA_SUB = 4'b0001,
        ULA_AND = 4'b0011,
        ULA_OR  = 4'b0100,
        ULA_XOR = 4'b0101,
        ULA_SLL = 4'b0110,
        ULA_SRL = 4'b0111,
        ULA_SRA = 4'b1000
    } ula_ctrl_t;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REGA = 2'b01;
    localparam logic [1:0] SRCA_REGB = 2'b10;

    localparam logic [2:0] SRCB_REGB   = 3'b000;
    localparam logic [2:0] SRCB_FOUR   = 3'b001;
    localparam logic [2:0] SRCB_IMM    = 3'b010;
    localparam logic [2:0] SRCB_IMMSH  = 3'b011;
    localparam logic [2:0] SRCB_SHAMT  = 3'b100;

    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the two opcodes that go through the address calculation state.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/decodificador_ula.sv
// decodificador_ula
// Combinational R-type function decoder.
//   funct_i    : IR[5:0]
//   ula_ctrl_o : ULA operation code for the function
//   shift_o    : 1 for sll/srl/sra (operand comes from rt, amount from shamt)
//   legal_o    : 1 when the function is one this core executes
module decodificador_ula
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] ula_ctrl_o,
    output logic       shift_o,
    output logic       legal_o
);

    always_comb begin
        ula_ctrl_o = ULA_ADD;
        shift_o    = 1'b0;
        legal_o    = 1'b1;
        case (funct_i)
            FUNCT_ADD: ula_ctrl_o = ULA_ADD;
            FUNCT_SUB: ula_ctrl_o = ULA_SUB;
            FUNCT_AND: ula_ctrl_o = ULA_AND;
            FUNCT_OR:  ula_ctrl_o = ULA_OR;
            FUNCT_XOR: ula_ctrl_o = ULA_XOR;
            FUNCT_SLL: begin
                ula_ctrl_o = ULA_SLL;
                shift_o    = 1'b1;
            end
            FUNCT_SRL: begin
                ula_ctrl_o = ULA_SRL;
                shift_o    = 1'b1;
            end
            FUNCT_SRA: begin
                ula_ctrl_o = ULA_SRA;
                shift_o    = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/unidade_controle_mc.sv
// unidade_controle_mc
// Moore control unit for the multicycle MIPS datapath. Sequences
// fetch/decode/execute/memory/write-back and drives every datapath select.
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   Op, Funct        : instruction register fields
//   Zero             : ULA zero flag (qualifies beq)
//   MemReady         : memory finishes its access this cycle
//   PCEn             : PC load enable = PCWrite | (Branch & Zero)
//   PCWrite, Branch, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg
//   ALUSrcA, ALUSrcB, PCSrc : datapath multiplexer selects
//   ULAControl       : ULA operation code
//   Excecao          : one-cycle pulse in DECODE for an unsupported instruction
module unidade_controle_mc
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [3:0] ULAControl,
    output logic       Excecao
);

    state_t     state_q, state_d;
    logic [3:0] decUla;
    logic       decShift;
    logic       decLegal;

    decodificador_ula u_decodificador_ula (
        .funct_i    (Funct),
        .ula_ctrl_o (decUla),
        .shift_o    (decShift),
        .legal_o    (decLegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_REGB;
        PCSrc      = PCSRC_ULA;
        ULAControl = ULA_ADD;
        Excecao    = 1'b0;

        case (state_q)
            // PC+4 is computed every fetch cycle, but PC and IR only load
            // on the cycle the memory actually returns the instruction.
            S_FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) begin
                    state_d = S_DECODE;
                end
            end
            // Branch target is precomputed into ALUOut while decoding.
            S_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                if (is_mem_op(Op)) begin
                    state_d = S_MEMADR;
                end else if (Op == OP_RTYPE && decLegal) begin
                    state_d = S_EXEC_R;
                end else if (Op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (Op == OP_ADDI) begin
                    state_d = S_ADDI_EX;
                end else if (Op == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    Excecao = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
                if (MemReady) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            // MemWrite stays asserted through the stall; the memory commits
            // the store only on the MemReady cycle.
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    state_d = S_FETCH;
                end
            end
            // Shifts operate on rt by shamt; the rest combine rs with rt.
            S_EXEC_R: begin
                ALUSrcA    = decShift ? SRCA_REGB : SRCA_REGA;
                ALUSrcB    = decShift ? SRCB_SHAMT : SRCB_REGB;
                ULAControl = decUla;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_REGA;
                ULAControl = ULA_SUB;
                Branch     = 1'b1;
                PCSrc      = PCSRC_ALUOUT;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                ALUSrcA = SRCA_REGA;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign PCEn = PCWrite | (Branch & Zero);

endmodule
